// File: rtl/pcie_tlp_fifo_pkt_pkg.sv
// Shared definitions for the store-and-forward TLP packet FIFO:
// beat record field widths, record packing order and write FSM encoding.
package pcie_tlp_fifo_pkt_pkg;

  // Fixed-width sideband fields carried with every beat
  localparam int BAR_ID_W   = 3;
  localparam int FUNC_NUM_W = 8;
  localparam int ERROR_W    = 4;

  // Record layout, LSB first: data | strb | hdr | bar_id | func_num | error | sop | eop
  function automatic int off_strb(input int dw);
    return dw;
  endfunction

  function automatic int off_hdr(input int dw, input int sw);
    return dw + sw;
  endfunction

  function automatic int off_bar_id(input int dw, input int sw, input int hw);
    return dw + sw + hw;
  endfunction

  function automatic int off_func_num(input int dw, input int sw, input int hw);
    return off_bar_id(dw, sw, hw) + BAR_ID_W;
  endfunction

  function automatic int off_error(input int dw, input int sw, input int hw);
    return off_func_num(dw, sw, hw) + FUNC_NUM_W;
  endfunction

  function automatic int off_sop(input int dw, input int sw, input int hw);
    return off_error(dw, sw, hw) + ERROR_W;
  endfunction

  function automatic int off_eop(input int dw, input int sw, input int hw);
    return off_sop(dw, sw, hw) + 1;
  endfunction

  function automatic int rec_width(input int dw, input int sw, input int hw);
    return off_eop(dw, sw, hw) + 1;
  endfunction

  // Write-side packet state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/pcie_tlp_fifo_ram.sv
// Simple dual-port beat storage: one write port, one registered read port.
// The read register only updates on rd_en, so it doubles as the held output stage.
module pcie_tlp_fifo_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port, holds its value when not enabled
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pcie_tlp_fifo_pkt.sv
// Store-and-forward TLP packet FIFO. Beats are written speculatively and only
// become visible to the reader once the eop beat commits; overflowing, malformed
// or errored TLPs are rewound instead of back-pressuring the upstream demux.
module pcie_tlp_fifo_pkt
  import pcie_tlp_fifo_pkt_pkg::*;
#(
  parameter int DEPTH          = 32,
  parameter int TLP_DATA_WIDTH = 256,
  parameter int TLP_STRB_WIDTH = TLP_DATA_WIDTH / 32,
  parameter int TLP_HDR_WIDTH  = 128,
  parameter int DROP_ERROR     = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [TLP_DATA_WIDTH-1:0] in_tlp_data,
  input  logic [TLP_STRB_WIDTH-1:0] in_tlp_strb,
  input  logic [TLP_HDR_WIDTH-1:0]  in_tlp_hdr,
  input  logic [2:0]                in_tlp_bar_id,
  input  logic [7:0]                in_tlp_func_num,
  input  logic [3:0]                in_tlp_error,
  input  logic                      in_tlp_valid,
  input  logic                      in_tlp_sop,
  input  logic                      in_tlp_eop,
  output logic                      in_tlp_ready,
  output logic [TLP_DATA_WIDTH-1:0] out_tlp_data,
  output logic [TLP_STRB_WIDTH-1:0] out_tlp_strb,
  output logic [TLP_HDR_WIDTH-1:0]  out_tlp_hdr,
  output logic [2:0]                out_tlp_bar_id,
  output logic [7:0]                out_tlp_func_num,
  output logic [3:0]                out_tlp_error,
  output logic                      out_tlp_valid,
  output logic                      out_tlp_sop,
  output logic                      out_tlp_eop,
  input  logic                      out_tlp_ready,
  output logic [$clog2(DEPTH):0]    status_count,
  output logic                      status_good,
  output logic                      status_drop_overflow,
  output logic                      status_drop_error
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int REC_W = rec_width(TLP_DATA_WIDTH, TLP_STRB_WIDTH, TLP_HDR_WIDTH);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  wr_state_e        state_reg, state_next;
  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    wr_ptr_commit_reg, wr_ptr_commit_next;
  logic [PW-1:0]    rd_ptr_reg;
  logic             good_next, drop_ovf_next, drop_err_next;
  logic             ram_we, idle_path, beat, bad_err, load;
  logic [PW-1:0]    base_ptr, used_wr, used_base;
  logic [REC_W-1:0] wr_rec, rd_rec;
  logic             rd_sop, rd_eop;

  assign beat    = in_tlp_valid & in_tlp_ready;
  assign bad_err = (DROP_ERROR != 0) && (in_tlp_error != 4'd0);

  // A sop in PKT abandons the partial TLP, so the new one starts at the commit point
  assign base_ptr  = (state_reg == ST_PKT && in_tlp_sop) ? wr_ptr_commit_reg : wr_ptr_reg;
  assign used_wr   = wr_ptr_reg - rd_ptr_reg;
  assign used_base = base_ptr - rd_ptr_reg;

  assign wr_rec = {in_tlp_eop, in_tlp_sop, in_tlp_error, in_tlp_func_num,
                   in_tlp_bar_id, in_tlp_hdr, in_tlp_strb, in_tlp_data};

  // Decode the accepted beat into store / commit / rewind actions and the next state
  always_comb begin
    state_next         = state_reg;
    wr_ptr_next        = wr_ptr_reg;
    wr_ptr_commit_next = wr_ptr_commit_reg;
    ram_we             = 1'b0;
    good_next          = 1'b0;
    drop_ovf_next      = 1'b0;
    drop_err_next      = 1'b0;
    idle_path          = 1'b0;
    if (beat) begin
      case (state_reg)
        ST_IDLE: idle_path = 1'b1;
        ST_PKT: begin
          if (in_tlp_sop) begin
            wr_ptr_next   = wr_ptr_commit_reg;
            drop_err_next = 1'b1;
            idle_path     = 1'b1;
          end else if (used_wr == DEPTH_P) begin
            wr_ptr_next = wr_ptr_commit_reg;
            if (in_tlp_eop) begin
              drop_ovf_next = 1'b1;
              state_next    = ST_IDLE;
            end else begin
              state_next = ST_DROP;
            end
          end else begin
            ram_we      = 1'b1;
            wr_ptr_next = wr_ptr_reg + ONE_P;
            if (in_tlp_eop) begin
              state_next = ST_IDLE;
              if (bad_err) begin
                wr_ptr_next   = wr_ptr_commit_reg;
                drop_err_next = 1'b1;
              end else begin
                wr_ptr_commit_next = wr_ptr_reg + ONE_P;
                good_next          = 1'b1;
              end
            end
          end
        end
        ST_DROP: begin
          if (in_tlp_sop) begin
            drop_ovf_next = 1'b1;
            idle_path     = 1'b1;
          end else if (in_tlp_eop) begin
            drop_ovf_next = 1'b1;
            state_next    = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase

      // Start-of-packet handling shared by IDLE and the restart cases
      if (idle_path) begin
        if (!in_tlp_sop) begin
          drop_err_next = 1'b1;
          state_next    = ST_IDLE;
        end else if (used_base == DEPTH_P) begin
          drop_ovf_next = 1'b1;
          state_next    = in_tlp_eop ? ST_IDLE : ST_DROP;
        end else begin
          ram_we      = 1'b1;
          wr_ptr_next = base_ptr + ONE_P;
          state_next  = in_tlp_eop ? ST_IDLE : ST_PKT;
          if (in_tlp_eop) begin
            if (bad_err) begin
              wr_ptr_next   = base_ptr;
              drop_err_next = 1'b1;
            end else begin
              wr_ptr_commit_next = base_ptr + ONE_P;
              good_next          = 1'b1;
            end
          end
        end
      end
    end
  end

  // Write FSM, pointers and registered status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg            <= ST_IDLE;
      wr_ptr_reg           <= '0;
      wr_ptr_commit_reg    <= '0;
      in_tlp_ready         <= 1'b0;
      status_good          <= 1'b0;
      status_drop_overflow <= 1'b0;
      status_drop_error    <= 1'b0;
    end else begin
      state_reg            <= state_next;
      wr_ptr_reg           <= wr_ptr_next;
      wr_ptr_commit_reg    <= wr_ptr_commit_next;
      in_tlp_ready         <= 1'b1;
      status_good          <= good_next;
      status_drop_overflow <= drop_ovf_next;
      status_drop_error    <= drop_err_next;
    end
  end

  // Refill the output stage whenever it is empty or being consumed
  assign load = (rd_ptr_reg != wr_ptr_commit_reg) && (!out_tlp_valid || out_tlp_ready);

  // Read pointer and output valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg    <= '0;
      out_tlp_valid <= 1'b0;
    end else if (load) begin
      rd_ptr_reg    <= rd_ptr_reg + ONE_P;
      out_tlp_valid <= 1'b1;
    end else if (out_tlp_ready) begin
      out_tlp_valid <= 1'b0;
    end
  end

  assign status_count = wr_ptr_commit_reg - rd_ptr_reg;

  pcie_tlp_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (base_ptr[AW-1:0]),
    .wr_data (wr_rec),
    .rd_en   (load),
    .rd_addr (rd_ptr_reg[AW-1:0]),
    .rd_data (rd_rec)
  );

  assign {rd_eop, rd_sop, out_tlp_error, out_tlp_func_num, out_tlp_bar_id,
          out_tlp_hdr, out_tlp_strb, out_tlp_data} = rd_rec;
  assign out_tlp_sop = rd_sop;
  assign out_tlp_eop = rd_eop;

endmodule

// File: tb/tb_pcie_tlp_fifo_pkt.sv
// Directed bench for the TLP packet FIFO. Two instances share the input bus:
// dut drops errored TLPs, dut0 passes them through and always has its consumer ready.
module tb_pcie_tlp_fifo_pkt;

  localparam int DW = 256;
  localparam int SW = 8;
  localparam int HW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [SW-1:0] in_strb = '0;
  logic [HW-1:0] in_hdr = '0;
  logic [2:0]    in_bar_id = '0;
  logic [7:0]    in_func = '0;
  logic [3:0]    in_error = '0;
  logic          in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic          out_ready = 1'b1;
  logic          z_ready = 1'b1;

  logic          o_in_ready, o_valid, o_sop, o_eop, o_good, o_ovf, o_err;
  logic [DW-1:0] o_data;
  logic [SW-1:0] o_strb;
  logic [HW-1:0] o_hdr;
  logic [2:0]    o_bar_id;
  logic [7:0]    o_func;
  logic [3:0]    o_error;
  logic [5:0]    o_count;

  logic          z_in_ready, z_valid, z_sop, z_eop, z_good, z_ovf, z_err;
  logic [DW-1:0] z_data;
  logic [SW-1:0] z_strb;
  logic [HW-1:0] z_hdr;
  logic [2:0]    z_bar_id;
  logic [7:0]    z_func;
  logic [3:0]    z_error;
  logic [5:0]    z_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_i;
  logic acc;

  always #5 clk = ~clk;

  pcie_tlp_fifo_pkt #(.DEPTH(32), .TLP_DATA_WIDTH(DW), .TLP_HDR_WIDTH(HW), .DROP_ERROR(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_tlp_data(in_data), .in_tlp_strb(in_strb), .in_tlp_hdr(in_hdr),
    .in_tlp_bar_id(in_bar_id), .in_tlp_func_num(in_func), .in_tlp_error(in_error),
    .in_tlp_valid(in_valid), .in_tlp_sop(in_sop), .in_tlp_eop(in_eop), .in_tlp_ready(o_in_ready),
    .out_tlp_data(o_data), .out_tlp_strb(o_strb), .out_tlp_hdr(o_hdr),
    .out_tlp_bar_id(o_bar_id), .out_tlp_func_num(o_func), .out_tlp_error(o_error),
    .out_tlp_valid(o_valid), .out_tlp_sop(o_sop), .out_tlp_eop(o_eop), .out_tlp_ready(out_ready),
    .status_count(o_count), .status_good(o_good),
    .status_drop_overflow(o_ovf), .status_drop_error(o_err)
  );

  pcie_tlp_fifo_pkt #(.DEPTH(32), .TLP_DATA_WIDTH(DW), .TLP_HDR_WIDTH(HW), .DROP_ERROR(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_tlp_data(in_data), .in_tlp_strb(in_strb), .in_tlp_hdr(in_hdr),
    .in_tlp_bar_id(in_bar_id), .in_tlp_func_num(in_func), .in_tlp_error(in_error),
    .in_tlp_valid(in_valid), .in_tlp_sop(in_sop), .in_tlp_eop(in_eop), .in_tlp_ready(z_in_ready),
    .out_tlp_data(z_data), .out_tlp_strb(z_strb), .out_tlp_hdr(z_hdr),
    .out_tlp_bar_id(z_bar_id), .out_tlp_func_num(z_func), .out_tlp_error(z_error),
    .out_tlp_valid(z_valid), .out_tlp_sop(z_sop), .out_tlp_eop(z_eop), .out_tlp_ready(z_ready),
    .status_count(z_count), .status_good(z_good),
    .status_drop_overflow(z_ovf), .status_drop_error(z_err)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] dval(input logic [31:0] tag);
    return {224'd0, tag};
  endfunction

  // One beat, presented for exactly one clock edge; returns 1 ns after that edge
  task automatic send(input logic sop, input logic eop, input logic [3:0] err, input logic [31:0] tag);
    in_valid  = 1'b1;
    in_sop    = sop;
    in_eop    = eop;
    in_error  = err;
    in_data   = dval(tag);
    in_hdr    = {96'd0, tag ^ 32'hA5A5_0000};
    in_strb   = 8'hFF;
    in_bar_id = tag[2:0];
    in_func   = tag[7:0];
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_ready", o_in_ready, 1'b0);
    chk("rst_count", o_count, 6'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", o_in_ready, 1'b1);

    // 3-beat TLP, consumer ready
    send(1'b1, 1'b0, 4'h0, 32'h11);
    send(1'b0, 1'b0, 4'h0, 32'h12);
    send(1'b0, 1'b1, 4'h0, 32'h13);
    chk("t1_good", o_good, 1'b1);
    chk("t1_count3", o_count, 6'd3);
    chk("t1_no_valid_yet", o_valid, 1'b0);
    idle(1);
    chk("t1_valid0", o_valid, 1'b1);
    chk("t1_data0", o_data, dval(32'h11));
    chk("t1_sop0", o_sop, 1'b1);
    chk("t1_hdr0", o_hdr, {96'd0, 32'hA5A5_0011});
    chk("t1_good_once", o_good, 1'b0);
    idle(1);
    chk("t1_data1", o_data, dval(32'h12));
    chk("t1_sopeop1", {o_sop, o_eop}, 2'b00);
    idle(1);
    chk("t1_data2", o_data, dval(32'h13));
    chk("t1_eop2", o_eop, 1'b1);
    chk("t1_count0", o_count, 6'd0);
    idle(1);
    chk("t1_valid_end", o_valid, 1'b0);

    // 40-beat TLP into a stalled consumer overflows
    out_ready = 1'b0;
    send(1'b1, 1'b0, 4'h0, 32'h200);
    for (int i = 1; i < 39; i++) begin
      send(1'b0, 1'b0, 4'h0, 32'h200 + i);
      if (i == 32) chk("t2_no_ovf_mid", o_ovf, 1'b0);
    end
    send(1'b0, 1'b1, 4'h0, 32'h227);
    chk("t2_ovf", o_ovf, 1'b1);
    chk("t2_no_good", o_good, 1'b0);
    chk("t2_count0", o_count, 6'd0);
    chk("t2_no_valid", o_valid, 1'b0);
    send(1'b1, 1'b1, 4'h0, 32'h300);
    chk("t2_good_after", o_good, 1'b1);
    idle(1);
    chk("t2_valid", o_valid, 1'b1);
    chk("t2_data", o_data, dval(32'h300));
    chk("t2_sopeop", {o_sop, o_eop}, 2'b11);
    out_ready = 1'b1;
    idle(1);
    chk("t2_drained", o_valid, 1'b0);

    // Error on eop: dropped by dut, passed by dut0
    send(1'b1, 1'b0, 4'h0, 32'h400);
    send(1'b0, 1'b1, 4'h1, 32'h401);
    chk("t3_drop_err", o_err, 1'b1);
    chk("t3_no_good", o_good, 1'b0);
    chk("t3_pass_good", z_good, 1'b1);
    idle(1);
    chk("t3_pass_valid", z_valid, 1'b1);
    chk("t3_pass_data0", z_data, dval(32'h400));
    chk("t3_pass_sop", z_sop, 1'b1);
    chk("t3_drop_novalid", o_valid, 1'b0);
    idle(1);
    chk("t3_pass_data1", z_data, dval(32'h401));
    chk("t3_pass_eop", z_eop, 1'b1);
    chk("t3_pass_error", z_error, 4'h1);
    idle(1);

    // Framing errors: stray beat, then sop in the middle of a packet
    send(1'b0, 1'b0, 4'h0, 32'h500);
    chk("t4_stray_err", o_err, 1'b1);
    send(1'b1, 1'b0, 4'h0, 32'h510);
    chk("t4_sop_noerr", o_err, 1'b0);
    send(1'b1, 1'b1, 4'h0, 32'h520);
    chk("t4_restart_err", o_err, 1'b1);
    chk("t4_restart_good", o_good, 1'b1);
    idle(1);
    chk("t4_valid", o_valid, 1'b1);
    chk("t4_data", o_data, dval(32'h520));
    chk("t4_func", o_func, 8'h20);
    idle(1);
    chk("t4_only_one", o_valid, 1'b0);

    // Back-to-back 1-beat TLPs up to full, then toggled drain
    out_ready = 1'b0;
    for (int i = 0; i < 33; i++) send(1'b1, 1'b1, 4'h0, 32'h600 + i);
    chk("t5_count32", o_count, 6'd32);
    send(1'b1, 1'b1, 4'h0, 32'h6FF);
    chk("t5_full_ovf", o_ovf, 1'b1);
    chk("t5_full_nogood", o_good, 1'b0);
    chk("t5_count_hold", o_count, 6'd32);
    exp_i = 0;
    for (int c = 0; c < 100 && exp_i < 33; c++) begin
      chk("t5_valid", o_valid, 1'b1);
      chk("t5_data", o_data, dval(32'h600 + exp_i));
      out_ready = c[0];
      acc = o_valid && out_ready;
      @(posedge clk);
      #1;
      if (acc) exp_i++;
    end
    chk("t5_all_read", 32'(exp_i), 32'd33);
    chk("t5_count_end", o_count, 6'd0);
    idle(2);
    chk("t5_no_extra", o_valid, 1'b0);

    // Asynchronous reset mid-packet with committed TLPs queued
    out_ready = 1'b0;
    send(1'b1, 1'b1, 4'h0, 32'h700);
    send(1'b1, 1'b1, 4'h0, 32'h701);
    send(1'b1, 1'b0, 4'h0, 32'h702);
    chk("t6_pre_valid", o_valid, 1'b1);
    chk("t6_pre_count", o_count, 6'd1);
    in_valid = 1'b1;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", o_valid, 1'b0);
    chk("t6_rst_ready", o_in_ready, 1'b0);
    chk("t6_rst_count", o_count, 6'd0);
    in_valid = 1'b0;
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_post_ready", o_in_ready, 1'b1);
    chk("t6_post_empty", o_valid, 1'b0);
    send(1'b1, 1'b1, 4'h0, 32'h800);
    chk("t6_post_good", o_good, 1'b1);
    idle(1);
    chk("t6_post_valid", o_valid, 1'b1);
    chk("t6_post_data", o_data, dval(32'h800));
    idle(1);
    chk("t6_post_drained", o_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pcie_tlp_fifo_pkt.md
Name: pcie_tlp_fifo_pkt

Overview:
Store-and-forward TLP packet FIFO that sits directly downstream of one output port of the BAR-ID TLP demultiplexer.
- Accepts single-segment TLP beats (data/strb/hdr/bar_id/func_num/error with sop/eop).
- Releases a TLP to the consumer only after its eop beat has been stored.
- Discards whole TLPs that overflow the buffer, are malformed, or carry a nonzero error field.
- Decouples the demux from slow per-BAR consumers and keeps the demux port from stalling mid-packet.

Parameters:
DEPTH, 32, storage entries (beats); power of two, >= 2
TLP_DATA_WIDTH, 256, TLP segment data width
TLP_STRB_WIDTH, TLP_DATA_WIDTH/32, dword strobe width
TLP_HDR_WIDTH, 128, TLP header width
DROP_ERROR, 1, 1 = drop TLPs whose eop beat carries error != 0; 0 = pass them through

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
in_tlp_data  in  TLP_DATA_WIDTH  input beat data
in_tlp_strb  in  TLP_STRB_WIDTH  input dword strobes
in_tlp_hdr  in  TLP_HDR_WIDTH  header, valid on sop
in_tlp_bar_id  in  3  BAR ID
in_tlp_func_num  in  8  function number
in_tlp_error  in  4  error flags
in_tlp_valid  in  1  beat valid
in_tlp_sop  in  1  first beat of TLP
in_tlp_eop  in  1  last beat of TLP
in_tlp_ready  out  1  beat accept
out_tlp_data/strb/hdr/bar_id/func_num/error  out  same widths as inputs  output beat fields
out_tlp_valid  out  1  output beat valid
out_tlp_sop  out  1  first beat
out_tlp_eop  out  1  last beat
out_tlp_ready  in  1  consumer accept
status_count  out  $clog2(DEPTH)+1  committed entries not yet read
status_good  out  1  pulse: TLP committed
status_drop_overflow  out  1  pulse: TLP dropped, buffer full
status_drop_error  out  1  pulse: TLP dropped, error or bad framing

Behaviour:
- Reset (rst_n low, asynchronous): all pointers 0; in_tlp_ready 0; out_tlp_valid 0; status pulses 0; status_count 0; drop flag and in-packet flag cleared. Data outputs hold don't-care values. Partial TLPs are discarded.
- After reset release, in_tlp_ready is 1 every cycle. Overflow is handled by dropping, never by backpressure. A beat is accepted on valid & ready.
- Pointers: wr_ptr (speculative), wr_ptr_commit, rd_ptr. Each is $clog2(DEPTH)+1 bits wide, with the MSB used as a wrap bit.
  - Full: (wr_ptr - rd_ptr) == DEPTH.
  - Empty to the reader: rd_ptr == wr_ptr_commit.
- Write state machine has three states: IDLE, PKT, DROP.
  - IDLE:
    - Beat without sop: discarded, status_drop_error pulses, stay in IDLE.
    - sop & eop beat: stored and committed in the same cycle.
    - sop only: stored, go to PKT.
  - PKT, beat while full: wr_ptr rewinds to wr_ptr_commit.
    - If the beat has eop: status_drop_overflow pulses, go to IDLE.
    - Otherwise: go to DROP.
  - PKT, beat with sop: the partial TLP is rewound and status_drop_error pulses. The new beat is then handled as in IDLE, in the same cycle.
  - PKT, eop beat, not full: stored.
    - If DROP_ERROR and error != 0: rewind, status_drop_error pulses.
    - Otherwise: wr_ptr_commit is set to wr_ptr+1 and status_good pulses.
    - Either way, go to IDLE.
  - DROP: discard beats until eop; on eop, status_drop_overflow pulses and go to IDLE. A sop beat in DROP pulses status_drop_overflow, then is handled as in IDLE.
- Full check: a sop beat arriving in IDLE while full is dropped like an overflow: status_drop_overflow pulses, then the FSM goes to IDLE if the beat has eop, otherwise to DROP.
- Read side: a registered output stage, one entry deep.
  - It loads from RAM when rd_ptr != wr_ptr_commit and (!out_tlp_valid | out_tlp_ready).
  - Latency: 1 cycle from commit to out_tlp_valid when empty.
  - Full throughput: one beat per cycle when the consumer is ready.
  - Output fields are stable while valid & !ready.
- Simultaneous commit and read in one cycle are both honoured.
- status_count = wr_ptr_commit - rd_ptr. It is updated on the clock edge after the event.

Decomposition:
- Shared package: beat record layout (field offsets/widths for data, strb, hdr, bar_id, func_num, error, sop, eop) and the FSM state encoding constants.
- One sub-module: pcie_tlp_fifo_ram, a simple dual-port RAM with one write port, one registered read port, and DEPTH x record width.

Test Plan:
- 3-beat TLP (sop, -, eop), consumer ready: out_tlp_valid rises 1 cycle after the eop is accepted; all 3 beats appear in order with identical fields; status_good pulses once; status_count returns to 0.
- DEPTH=32, consumer stalled, a 40-beat TLP: status_drop_overflow pulses at eop; no output; status_count 0. A following 1-beat TLP is delivered.
- 2-beat TLP with error=4'h1 on eop, DROP_ERROR=1: dropped with a status_drop_error pulse. With DROP_ERROR=0: delivered with error=1.
- Beat with no sop in IDLE: discarded with a status_drop_error pulse. sop arriving mid-packet: the first partial TLP is dropped and the second is delivered intact.
- Back-to-back 1-beat TLPs with out_tlp_ready toggling 1/0: no beat is lost or duplicated; fields are held while stalled; status_count tracks occupancy, including 32 at full.
- rst_n asserted mid-packet with 2 committed TLPs queued: outputs go 0 asynchronously; after release the FIFO is empty and the next TLP is delivered normally.
